// File: rtl/isp_pkg.sv
// Shared ISP definitions: CFA pattern codes, RGB565 field layout, RAW10 and beat geometry.
package isp_pkg;

   typedef enum logic [1:0] {
      RGGB = 2'd0,
      GRBG = 2'd1,
      GBRG = 2'd2,
      BGGR = 2'd3
   } bayer_e;

   typedef enum logic [1:0] {
      WAIT_SYNC = 2'd0,
      ACTIVE    = 2'd1,
      DONE      = 2'd2
   } fsm_e;

   localparam int PIX_PER_BEAT = 4;
   localparam int RAW10_W      = 10;
   localparam int RGB565_W     = 16;
   localparam int R5_LSB       = 11;
   localparam int G6_LSB       = 5;
   localparam int B5_LSB       = 0;
   localparam int RGB_BEAT_W   = PIX_PER_BEAT * RGB565_W;
   localparam int RAW_BEAT_W   = PIX_PER_BEAT * RAW10_W;

   // 00=R, 01/10=G, 11=B after folding in the sensor's CFA phase.
   function automatic logic [1:0] cfa_idx(input logic py, input logic px, input logic [1:0] pat);
      return {py, px} ^ pat;
   endfunction

endpackage

// File: rtl/rgb565_to_bayer_raw10_if.sv
// Stream bundle between the RGB565 source and the RAW10 re-mosaic stage.
interface rgb565_to_bayer_raw10_if;
   import isp_pkg::*;

   logic                  I_V_sync;
   logic                  I_RGB_Vaild;
   logic [RGB_BEAT_W-1:0] I_RGB_Data;
   logic                  O_Raw_V_sync;
   logic                  O_Raw_Vaild;
   logic [RAW_BEAT_W-1:0] O_Raw_Data;
   logic                  O_Line_End;
   logic                  O_Frame_End;
   logic                  O_Frame_Err;

   modport master (
      output I_V_sync, I_RGB_Vaild, I_RGB_Data,
      input  O_Raw_V_sync, O_Raw_Vaild, O_Raw_Data, O_Line_End, O_Frame_End, O_Frame_Err
   );

   modport slave (
      input  I_V_sync, I_RGB_Vaild, I_RGB_Data,
      output O_Raw_V_sync, O_Raw_Vaild, O_Raw_Data, O_Line_End, O_Frame_End, O_Frame_Err
   );

endinterface

// File: rtl/rgb565_pix_to_raw10.sv
// One RGB565 pixel to one RAW10 sample: pick the CFA channel, widen by bit replication.
module rgb565_pix_to_raw10
   import isp_pkg::*;
(
   input  logic [RGB565_W-1:0] i_pix,
   input  logic [1:0]          i_idx,
   output logic [RAW10_W-1:0]  o_raw
);

   logic [4:0] r5;
   logic [5:0] g6;
   logic [4:0] b5;

   assign r5 = i_pix[R5_LSB +: 5];
   assign g6 = i_pix[G6_LSB +: 6];
   assign b5 = i_pix[B5_LSB +: 5];

   always_comb begin
      case (i_idx)
         2'b00:   o_raw = {r5, r5};
         2'b11:   o_raw = {b5, b5};
         default: o_raw = {g6, g6[5:2]};
      endcase
   end

endmodule

// File: rtl/rgb565_to_bayer_raw10.sv
// Re-mosaics 4-pixel RGB565 beats into 4-pixel RAW10 Bayer beats with frame geometry tracking.
module rgb565_to_bayer_raw10
   import isp_pkg::*;
#(
   parameter int Image_width   = 1920,
   parameter int Image_Higth   = 1080,
   parameter int Pixel_Num     = PIX_PER_BEAT,
   parameter int Col_Max       = Image_width / Pixel_Num,
   parameter int BAYER_PATTERN = 0
) (
   input  logic I_CLK,
   input  logic I_Rst_n,
   rgb565_to_bayer_raw10_if.slave bus
);

   localparam int            STAGES   = 2;
   localparam int            CW       = (Col_Max > 1) ? $clog2(Col_Max) : 1;
   localparam int            RW       = $clog2(Image_Higth + 1);
   localparam logic [CW-1:0] COL_LAST = CW'(Col_Max - 1);
   localparam logic [RW-1:0] ROW_LAST = RW'(Image_Higth - 1);
   localparam logic [1:0]    PAT      = 2'(BAYER_PATTERN);

   fsm_e                  state_q, state_d;
   logic [CW-1:0]         col_q, col_d;
   logic [RW-1:0]         row_q, row_d;
   logic                  err_q, err_d;
   logic [STAGES-1:0]     vld_pipe_q, vld_pipe_d;
   logic [STAGES-1:0]     vs_pipe_q, vs_pipe_d;
   logic [RGB_BEAT_W-1:0] s1_data_q, s1_data_d;
   logic                  s1_py_q, s1_py_d;
   logic [CW-1:0]         s1_col_q, s1_col_d;
   logic                  s1_last_row_q, s1_last_row_d;
   logic [RAW_BEAT_W-1:0] s2_data_q, s2_data_d;
   logic                  s2_line_end_q, s2_line_end_d;
   logic                  s2_frame_end_q, s2_frame_end_d;

   logic                                accept;
   logic                                last_col;
   logic                                last_beat;
   logic [Pixel_Num-1:0][RAW10_W-1:0]   raw_lane;

   for (genvar j = 0; j < Pixel_Num; j++) begin : g_lane
      localparam logic PX = 1'(j % 2);
      rgb565_pix_to_raw10 u_pix (
         .i_pix (s1_data_q[RGB_BEAT_W-1-RGB565_W*j -: RGB565_W]),
         .i_idx (cfa_idx(s1_py_q, PX, PAT)),
         .o_raw (raw_lane[j])
      );
   end

   always_comb begin
      accept    = bus.I_RGB_Vaild && !bus.I_V_sync && (state_q == ACTIVE);
      last_col  = (col_q == COL_LAST);
      last_beat = last_col && (row_q == ROW_LAST);

      state_d = state_q;
      col_d   = col_q;
      row_d   = row_q;
      err_d   = err_q;

      // Sync wins over any beat in the same cycle; a sync mid-frame flags a short frame.
      if (bus.I_V_sync) begin
         state_d = ACTIVE;
         col_d   = '0;
         row_d   = '0;
         err_d   = (state_q == ACTIVE) && ((col_q != '0) || (row_q != '0));
      end else if (bus.I_RGB_Vaild) begin
         case (state_q)
            ACTIVE: begin
               col_d = last_col ? '0 : col_q + CW'(1);
               if (last_col) row_d = row_q + RW'(1);
               if (last_beat) state_d = DONE;
            end
            DONE:    err_d = 1'b1;
            default: ;
         endcase
      end

      vld_pipe_d    = {vld_pipe_q[0], accept};
      vs_pipe_d     = {vs_pipe_q[0], bus.I_V_sync};
      s1_data_d     = accept ? bus.I_RGB_Data : '0;
      s1_py_d       = accept && row_q[0];
      s1_col_d      = accept ? col_q : '0;
      s1_last_row_d = accept && (row_q == ROW_LAST);

      s2_data_d      = vld_pipe_q[0] ? raw_lane : '0;
      s2_line_end_d  = vld_pipe_q[0] && (s1_col_q == COL_LAST);
      s2_frame_end_d = s2_line_end_d && s1_last_row_q;
   end

   always_ff @(posedge I_CLK or negedge I_Rst_n) begin
      if (!I_Rst_n) begin
         state_q        <= WAIT_SYNC;
         col_q          <= '0;
         row_q          <= '0;
         err_q          <= 1'b0;
         vld_pipe_q     <= '0;
         vs_pipe_q      <= '0;
         s1_data_q      <= '0;
         s1_py_q        <= 1'b0;
         s1_col_q       <= '0;
         s1_last_row_q  <= 1'b0;
         s2_data_q      <= '0;
         s2_line_end_q  <= 1'b0;
         s2_frame_end_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         col_q          <= col_d;
         row_q          <= row_d;
         err_q          <= err_d;
         vld_pipe_q     <= vld_pipe_d;
         vs_pipe_q      <= vs_pipe_d;
         s1_data_q      <= s1_data_d;
         s1_py_q        <= s1_py_d;
         s1_col_q       <= s1_col_d;
         s1_last_row_q  <= s1_last_row_d;
         s2_data_q      <= s2_data_d;
         s2_line_end_q  <= s2_line_end_d;
         s2_frame_end_q <= s2_frame_end_d;
      end
   end

   assign bus.O_Raw_V_sync = vs_pipe_q[STAGES-1];
   assign bus.O_Raw_Vaild  = vld_pipe_q[STAGES-1];
   assign bus.O_Raw_Data   = s2_data_q;
   assign bus.O_Line_End   = s2_line_end_q;
   assign bus.O_Frame_End  = s2_frame_end_q;
   assign bus.O_Frame_Err  = err_q;

endmodule
